// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from a single 4-bit adder slice, stepped one nibble per cycle LSB first.
// Valid/ready on both sides; the result registers stay stable while out_valid is high.

module fullAdder_4Bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = a_i + b_i + {3'b000, c_i};
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// ADD   | one nibble per cycle through the shared slice, idx selects the nibble
// DONE  | result held with out_valid high until out_ready
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [3:0] add_a, add_b, add_s;
  logic       add_c;

  assign add_a = a_q[4*idx_q +: 4];
  assign add_b = b_q[4*idx_q +: 4];

  fullAdder_4Bit u_slice (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[4*idx_q +: 4] = add_s;
        carry_d             = add_c;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_c;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ADD) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench: directed 16-bit cases plus a randomized 8-bit run against a queue-based
// arithmetic model of a + b + cin with random backpressure.

module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst16, iv16, ir16, cin16, ov16, or16, co16, bz16;
  logic [15:0] a16, b16, s16;
  logic        rst8, iv8, ir8, cin8, ov8, or8, co8, bz8;
  logic [7:0]  a8, b8, s8;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation: accept, count ADD cycles, optionally stall, then retire.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input int stall, input bit inject);
    int          cyc;
    logic [16:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
    cyc = 0;
    while (!ir16 && cyc < 50) begin tick(); cyc++; end
    check("in_ready_idle", {31'd0, ir16}, 32'd1);
    a16 = a; b16 = b; cin16 = c; iv16 = 1'b1; or16 = (stall == 0);
    tick();
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    check("in_ready_after_accept", {31'd0, ir16}, 32'd0);
    check("busy_in_add", {31'd0, bz16}, 32'd1);
    cyc = 0;
    while (!ov16 && cyc < 20) begin
      if (inject && cyc == 1) begin iv16 = 1'b1; a16 = 16'hAAAA; end
      else iv16 = 1'b0;
      tick();
      cyc++;
    end
    iv16 = 1'b0;
    check("latency_add_cycles", cyc, 32'd4);
    check("sum16", {16'd0, s16}, {16'd0, exp[15:0]});
    check("cout16", {31'd0, co16}, {31'd0, exp[16]});
    for (int k = 0; k < stall; k++) begin
      check("hold_valid", {31'd0, ov16}, 32'd1);
      check("hold_sum", {15'd0, co16, s16}, {15'd0, exp});
      check("hold_in_ready", {31'd0, ir16}, 32'd0);
      tick();
    end
    or16 = 1'b1;
    tick();
    check("out_valid_dropped", {31'd0, ov16}, 32'd0);
    check("in_ready_back", {31'd0, ir16}, 32'd1);
    check("busy_idle", {31'd0, bz16}, 32'd0);
  endtask

  logic [8:0] q[$];
  logic [8:0] exp8;
  int age, n_acc, n_hs, guard;
  bit acc, hs;

  initial begin
    rst16 = 1'b1; iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    rst8  = 1'b1; iv8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, ir16}, 32'd1);
    check("rst_out_valid", {31'd0, ov16}, 32'd0);
    check("rst_busy", {31'd0, bz16}, 32'd0);
    check("rst_sum_cout", {15'd0, co16, s16}, 32'd0);
    tick(); tick();
    rst16 = 1'b0; rst8 = 1'b0;
    tick();

    run16(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

    // Abort after two ADD cycles; the partially written sum must be wiped.
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; iv16 = 1'b1; or16 = 1'b1;
    tick();
    iv16 = 1'b0;
    tick(); tick();
    check("pre_reset_sum_touched", {31'd0, (s16 != 16'h5555) ? 1'b1 : 1'b0}, 32'd1);
    rst16 = 1'b1;
    #1;
    check("midreset_out_valid", {31'd0, ov16}, 32'd0);
    check("midreset_sum", {16'd0, s16}, 32'd0);
    check("midreset_cout", {31'd0, co16}, 32'd0);
    check("midreset_in_ready", {31'd0, ir16}, 32'd1);
    check("midreset_busy", {31'd0, bz16}, 32'd0);
    tick();
    rst16 = 1'b0;
    tick();
    run16(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    run16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run16(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    run16(16'h8000, 16'h8000, 1'b0, 10, 1'b0);
    run16(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 20; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

    // Randomized 8-bit run: an operation is outstanding from accept to result handshake.
    age = 0; n_acc = 0; n_hs = 0;
    for (int cy = 0; cy < 12000; cy++) begin
      if (!iv8) begin
        iv8  = ($urandom_range(0, 3) != 0);
        a8   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        b8   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        cin8 = 1'($urandom);
      end
      or8 = ($urandom_range(0, 2) != 0);
      if (q.size() != 0) age++;
      check("in_ready8", {31'd0, ir8}, {31'd0, (q.size() == 0) ? 1'b1 : 1'b0});
      check("out_valid8", {31'd0, ov8}, {31'd0, (q.size() != 0 && age >= 3) ? 1'b1 : 1'b0});
      hs  = ov8 && or8;
      acc = iv8 && ir8;
      if (hs) begin
        n_hs++;
        if (q.size() == 0) check("spurious_result8", 32'd1, 32'd0);
        else begin
          exp8 = q.pop_front();
          check("sum8", {23'd0, co8, s8}, {23'd0, exp8});
        end
      end
      if (acc) begin
        q.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
        age = 0;
        n_acc++;
      end
      tick();
      if (acc) begin
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      if (ov8) begin
        n_hs++;
        exp8 = q.pop_front();
        check("sum8_drain", {23'd0, co8, s8}, {23'd0, exp8});
      end
      tick();
      guard++;
    end
    check("drain_empty", q.size(), 32'd0);
    check("accepts_vs_results", n_hs, n_acc);
    check("some_ops_done", {31'd0, (n_acc > 1000) ? 1'b1 : 1'b0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
